// File: rtl/sobel_apb_regs_if.sv
// APB3 bus bundle between the interconnect (master) and the Sobel register bank (slave).
interface sobel_apb_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/sobel_apb_regs.sv
// Sobel configuration register bank behind an APB3 completer.
// Holds threshold/geometry/kernels, issues the frame start pulse and
// tracks busy/done/config-error status with a level interrupt.
module sobel_apb_regs #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_LSBS   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  sobel_apb_regs_if.slave        apb,
  input  logic                   sobel_done,
  output logic [7:0]             threshold,
  output logic [15:0]            img_width,
  output logic [15:0]            img_height,
  output logic [31:0]            total_pixels,
  output logic [31:0]            kernel1,
  output logic [31:0]            kernel2,
  output logic [31:0]            kernel3,
  output logic [31:0]            kernel4,
  output logic                   start_pulse,
  output logic                   busy,
  output logic                   irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;  // first PENABLE cycle of a transfer
  localparam logic [1:0] ST_ACCESS = 2'd2;  // later PENABLE cycles (wait states)
  localparam int         WW        = ADDR_LSBS - 2;

  logic [1:0]    state;
  logic [2:0]    wait_cnt;
  logic          irq_en;
  logic          done_flag;
  logic          cfg_err;
  logic [WW-1:0] word;
  logic          aligned, is_reg, is_ctrl, is_status, mapped;
  logic          xfer_done, cfg_ok, start_req, err;
  logic          wr_ok, ctrl_wr, status_wr, start_fire, cfg_fail;
  logic [31:0]   rd_mux;
  logic          unused_addr_bits;

  // Address decode: word index of the aligned byte address, upper bits ignored.
  assign word             = apb.PADDR[ADDR_LSBS-1:2];
  assign aligned          = apb.PADDR[1:0] == 2'b00;
  assign is_reg           = aligned && (word < WW'(8));
  assign is_ctrl          = aligned && (word == WW'(8));
  assign is_status        = aligned && (word == WW'(9));
  assign mapped           = is_reg || is_ctrl || is_status;
  assign unused_addr_bits = ^apb.PADDR[31:ADDR_LSBS];

  // Completion happens on the PENABLE cycle where the wait counter has run out.
  assign xfer_done  = (state != ST_IDLE) && apb.PSEL && apb.PENABLE
                      && (wait_cnt == 3'(WAIT_STATES));
  assign cfg_ok     = (img_width != '0) && (img_height != '0)
                      && (total_pixels == (32'(img_width) * 32'(img_height)));
  assign start_req  = is_ctrl && apb.PWRITE && apb.PWDATA[0];
  assign err        = !mapped
                      || (apb.PWRITE && is_reg && busy)
                      || (start_req && (busy || !cfg_ok));
  assign wr_ok      = xfer_done && apb.PWRITE && !err;
  // IRQ_EN follows every CTRL write, even one whose START is refused.
  assign ctrl_wr    = xfer_done && apb.PWRITE && is_ctrl;
  assign status_wr  = wr_ok && is_status;
  assign start_fire = xfer_done && start_req && !busy && cfg_ok;
  assign cfg_fail   = xfer_done && start_req && !busy && !cfg_ok;

  // Read data mux for the currently addressed register.
  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    if (is_reg) begin
      case (word[2:0])
        3'd0: rd_mux = {24'd0, threshold};
        3'd1: rd_mux = {16'd0, img_width};
        3'd2: rd_mux = {16'd0, img_height};
        3'd3: rd_mux = total_pixels;
        3'd4: rd_mux = kernel1;
        3'd5: rd_mux = kernel2;
        3'd6: rd_mux = kernel3;
        3'd7: rd_mux = kernel4;
      endcase
    end else if (is_ctrl) begin
      rd_mux = {30'd0, irq_en, 1'b0};
    end else if (is_status) begin
      rd_mux = {29'd0, cfg_err, done_flag, busy};
    end
  end

  assign apb.PREADY  = xfer_done;
  assign apb.PSLVERR = xfer_done && err;
  assign apb.PRDATA  = (xfer_done && !apb.PWRITE && !err) ? rd_mux : '0;

  // APB transfer FSM with wait-state counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            state    <= ST_SETUP;
            wait_cnt <= '0;
          end
        end
        default: begin
          if (!apb.PSEL) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (!apb.PENABLE) begin
            state    <= ST_SETUP;
            wait_cnt <= '0;
          end else if (xfer_done) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            state    <= ST_ACCESS;
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
      endcase
    end
  end

  // Configuration registers, committed at the end of a good write.
  always_ff @(posedge clk) begin
    // NOTE: the register bank is individual flops, so it is cleared by reset like any other state.
    if (reset) begin
      threshold    <= '0;
      img_width    <= '0;
      img_height   <= '0;
      total_pixels <= '0;
      kernel1      <= '0;
      kernel2      <= '0;
      kernel3      <= '0;
      kernel4      <= '0;
      irq_en       <= 1'b0;
    end else begin
      if (wr_ok && is_reg) begin
        case (word[2:0])
          3'd0: threshold    <= apb.PWDATA[7:0];
          3'd1: img_width    <= apb.PWDATA[15:0];
          3'd2: img_height   <= apb.PWDATA[15:0];
          3'd3: total_pixels <= apb.PWDATA;
          3'd4: kernel1      <= apb.PWDATA;
          3'd5: kernel2      <= apb.PWDATA;
          3'd6: kernel3      <= apb.PWDATA;
          3'd7: kernel4      <= apb.PWDATA;
        endcase
      end
      if (ctrl_wr) irq_en <= apb.PWDATA[1];
    end
  end

  // Frame status: start/busy/done/config error and the registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_pulse <= 1'b0;
      busy        <= 1'b0;
      done_flag   <= 1'b0;
      cfg_err     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      start_pulse <= start_fire;
      if (start_fire)               busy <= 1'b1;
      else if (sobel_done)          busy <= 1'b0;
      // Hardware set beats a same-cycle write-1-to-clear.
      if (sobel_done && busy)                 done_flag <= 1'b1;
      else if (status_wr && apb.PWDATA[1])    done_flag <= 1'b0;
      if (cfg_fail)                           cfg_err   <= 1'b1;
      else if (status_wr && apb.PWDATA[2])    cfg_err   <= 1'b0;
      irq <= irq_en && done_flag;
    end
  end

endmodule

// File: tb/tb_sobel_apb_regs.sv
// Self-checking bench for sobel_apb_regs: directed plan plus randomized APB traffic,
// run on a zero-wait-state instance and a three-wait-state instance.
module tb_sobel_apb_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite, sobel_done;
  logic [31:0] paddr, pwdata;
  int          dut_sel;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sobel_apb_regs_if apb0 ();
  sobel_apb_regs_if apb3 ();

  assign apb0.PSEL    = psel && (dut_sel == 0);
  assign apb0.PENABLE = penable;
  assign apb0.PWRITE  = pwrite;
  assign apb0.PADDR   = paddr;
  assign apb0.PWDATA  = pwdata;
  assign apb3.PSEL    = psel && (dut_sel == 1);
  assign apb3.PENABLE = penable;
  assign apb3.PWRITE  = pwrite;
  assign apb3.PADDR   = paddr;
  assign apb3.PWDATA  = pwdata;

  logic [7:0]  th  [2];
  logic [15:0] wd  [2];
  logic [15:0] ht  [2];
  logic [31:0] tot [2];
  logic [31:0] k1  [2];
  logic [31:0] k2  [2];
  logic [31:0] k3  [2];
  logic [31:0] k4  [2];
  logic        sp  [2];
  logic        bz  [2];
  logic        iq  [2];

  sobel_apb_regs #(.WAIT_STATES(0), .ADDR_LSBS(6)) dut0 (
    .clk(clk), .reset(reset), .apb(apb0), .sobel_done(sobel_done && (dut_sel == 0)),
    .threshold(th[0]), .img_width(wd[0]), .img_height(ht[0]), .total_pixels(tot[0]),
    .kernel1(k1[0]), .kernel2(k2[0]), .kernel3(k3[0]), .kernel4(k4[0]),
    .start_pulse(sp[0]), .busy(bz[0]), .irq(iq[0])
  );

  sobel_apb_regs #(.WAIT_STATES(3), .ADDR_LSBS(6)) dut3 (
    .clk(clk), .reset(reset), .apb(apb3), .sobel_done(sobel_done && (dut_sel == 1)),
    .threshold(th[1]), .img_width(wd[1]), .img_height(ht[1]), .total_pixels(tot[1]),
    .kernel1(k1[1]), .kernel2(k2[1]), .kernel3(k3[1]), .kernel4(k4[1]),
    .start_pulse(sp[1]), .busy(bz[1]), .irq(iq[1])
  );

  logic        pready, pslverr;
  logic [31:0] prdata;
  assign pready  = (dut_sel == 1) ? apb3.PREADY  : apb0.PREADY;
  assign pslverr = (dut_sel == 1) ? apb3.PSLVERR : apb0.PSLVERR;
  assign prdata  = (dut_sel == 1) ? apb3.PRDATA  : apb0.PRDATA;

  // Reference model: register file as an array plus status flags.
  logic [31:0] m_reg [8];
  bit          m_busy, m_done, m_cfg_err, m_irq_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (dut ws=%0d): got=%0h expected=%0h", tag, dut_sel * 3, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_mask(input int i);
    if (i == 0) return 32'h0000_00FF;
    if (i == 1 || i == 2) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_busy = 0; m_done = 0; m_cfg_err = 0; m_irq_en = 0;
  endtask

  // Expected response of one completed transfer, then the resulting state.
  task automatic model_xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input bit dn,
                            output logic [31:0] erd, output bit eerr, output bit estart);
    int  off;
    int  idx;
    bit  cfg_good;
    off = int'(a[5:0]);
    idx = off / 4;
    erd = '0; eerr = 0; estart = 0;
    cfg_good = (m_reg[1] != 0) && (m_reg[2] != 0)
               && (longint'(m_reg[3]) == longint'(m_reg[1]) * longint'(m_reg[2]));
    if ((off % 4) != 0 || off > 'h24) begin
      eerr = 1;
    end else if (!w) begin
      if (idx < 8)       erd = m_reg[idx];
      else if (idx == 8) erd = {30'd0, m_irq_en, 1'b0};
      else               erd = {29'd0, m_cfg_err, m_done, m_busy};
    end else if (idx < 8) begin
      if (m_busy) eerr = 1;
      else        m_reg[idx] = d & reg_mask(idx);
    end else if (idx == 8) begin
      m_irq_en = d[1];
      if (d[0]) begin
        if (m_busy)        eerr = 1;
        else if (cfg_good) estart = 1;
        else begin eerr = 1; m_cfg_err = 1; end
      end
    end else begin
      if (d[1]) m_done = 0;
      if (d[2]) m_cfg_err = 0;
    end
    if (dn && m_busy) begin m_busy = 0; m_done = 1; end
    if (estart) m_busy = 1;
  endtask

  // Drive one APB transfer and capture the completion-cycle response.
  task automatic apb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input bit dn,
                          output logic [31:0] rd, output bit err);
    int n;
    bit got;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    check("setup_quiet", {pready, pslverr, prdata}, 0);
    @(posedge clk); #1;
    penable = 1;
    n = 0; got = 0; rd = '0; err = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (pready) begin
        got = 1; rd = prdata; err = pslverr;
        if (dn) sobel_done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("penable_cycles@%h", a), n, (dut_sel == 1) ? 4 : 1);
    @(posedge clk); #1;
    psel = 0; penable = 0; sobel_done = 0;
  endtask

  task automatic check_outs();
    check("threshold", th[dut_sel], m_reg[0][7:0]);
    check("img_width", wd[dut_sel], m_reg[1][15:0]);
    check("img_height", ht[dut_sel], m_reg[2][15:0]);
    check("total_pixels", tot[dut_sel], m_reg[3]);
    check("kernel1", k1[dut_sel], m_reg[4]);
    check("kernel2", k2[dut_sel], m_reg[5]);
    check("kernel3", k3[dut_sel], m_reg[6]);
    check("kernel4", k4[dut_sel], m_reg[7]);
  endtask

  task automatic do_xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input bit dn,
                         output logic [31:0] rd, output bit err);
    logic [31:0] erd;
    bit eerr, estart;
    apb_xfer(w, a, d, dn, rd, err);
    model_xfer(w, a, d, dn, erd, eerr, estart);
    check($sformatf("prdata@%h", a), rd, erd);
    check($sformatf("pslverr@%h", a), err, eerr);
    @(negedge clk);
    check("start_pulse", sp[dut_sel], estart);
    check("busy", bz[dut_sel], m_busy);
    @(negedge clk);
    check("start_pulse_width", sp[dut_sel], 0);
    check("irq", iq[dut_sel], m_irq_en & m_done);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output bit err);
    logic [31:0] rd;
    do_xfer(1, a, d, 0, rd, err);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bit err;
    do_xfer(0, a, 32'h0, 0, v, err);
  endtask

  task automatic pulse_done();
    bit old_irq;
    old_irq = m_irq_en & m_done;
    @(posedge clk); #1 sobel_done = 1;
    @(posedge clk); #1 sobel_done = 0;
    if (m_busy) begin m_busy = 0; m_done = 1; end
    @(negedge clk);
    check("busy_after_done", bz[dut_sel], m_busy);
    check("irq_lag", iq[dut_sel], old_irq);
    @(negedge clk);
    check("irq_after_done", iq[dut_sel], m_irq_en & m_done);
  endtask

  task automatic do_reset();
    psel = 0; penable = 0; sobel_done = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    model_reset();
    @(negedge clk);
    check("rst_outputs", {sp[dut_sel], bz[dut_sel], iq[dut_sel], pready, pslverr}, 0);
    check_outs();
  endtask

  task automatic apb_abort(input logic [31:0] a, input logic [31:0] d, input int k);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1 penable = 1;
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic run_directed();
    logic [31:0] v;
    bit e;
    do_reset();
    wr(32'h00, 100, e); wr(32'h04, 10, e); wr(32'h08, 10, e); wr(32'h0C, 100, e);
    wr(32'h10, 1, e); wr(32'h14, 2, e); wr(32'h18, 32'hFFFF_FFFF, e); wr(32'h1C, 32'hFFFF_FFFE, e);
    for (int i = 0; i < 10; i++) rd(i * 4, v);
    check_outs();
    // Valid start, completion and W1C of DONE.
    wr(32'h20, 32'h3, e);
    rd(32'h24, v); check("status_busy", v, 32'h1);
    pulse_done();
    rd(32'h24, v); check("status_done", v, 32'h2);
    wr(32'h24, 32'h2, e);
    // Config check failures.
    wr(32'h0C, 99, e); wr(32'h20, 32'h1, e); check("cfg_total_err", e, 1);
    rd(32'h24, v); check("status_cfg_err", v, 32'h4);
    wr(32'h24, 32'h4, e);
    wr(32'h04, 0, e); wr(32'h0C, 0, e); wr(32'h20, 32'h1, e); check("cfg_zero_err", e, 1);
    rd(32'h24, v); check("status_cfg_err2", v, 32'h4);
    wr(32'h24, 32'h4, e);
    // Busy protection.
    wr(32'h04, 10, e); wr(32'h0C, 100, e); wr(32'h20, 32'h3, e);
    wr(32'h04, 20, e); check("busy_wr_err", e, 1);
    rd(32'h04, v); check("width_kept", v, 10);
    wr(32'h20, 32'h3, e); check("busy_start_err", e, 1);
    // DONE set beats same-cycle W1C.
    do_xfer(1, 32'h24, 32'h2, 1, v, e);
    rd(32'h24, v); check("done_set_wins", v, 32'h2);
    // START coinciding with the frame-ending sobel_done is refused.
    wr(32'h24, 32'h2, e); wr(32'h20, 32'h3, e);
    do_xfer(1, 32'h20, 32'h3, 1, v, e); check("start_vs_done_err", e, 1);
    // Unmapped, misaligned and aliased addresses.
    rd(32'h28, v); wr(32'h3C, 32'h1234, e); rd(32'h02, v);
    rd(32'hABCD_0004, v); check("alias_width", v, 10);
    // Abandoned transfer leaves THRESH alone.
    apb_abort(32'h00, 32'h55, (dut_sel == 1) ? 2 : 0);
    rd(32'h00, v); check("abort_no_effect", v, 100);
    // Reset while busy with DONE and irq set.
    wr(32'h20, 32'h3, e);
    check("pre_reset_state", {bz[dut_sel], iq[dut_sel]}, 2'b11);
    do_reset();
    for (int i = 0; i < 10; i++) rd(i * 4, v);
    pulse_done();
    rd(32'h24, v); check("status_after_reset", v, 0);
  endtask

  task automatic run_random(input int count);
    logic [31:0] v, a, d;
    bit e;
    int sel, w, h, idx;
    for (int it = 0; it < count; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        w = $urandom_range(1, 400);
        h = $urandom_range(1, 400);
        wr(32'h04, w, e); wr(32'h08, h, e); wr(32'h0C, w * h, e);
      end else if (sel == 1) begin
        pulse_done();
      end else if (sel == 2) begin
        wr(32'h20, {30'd0, 1'($urandom_range(0, 1)), 1'b1}, e);
      end else begin
        idx = $urandom_range(0, 12);
        if (idx < 10)       a = idx * 4;
        else if (idx == 10) a = 32'h28;
        else if (idx == 11) a = 32'h3C;
        else                a = 32'h05;
        a = a | ($urandom & 32'hFFFF_FFC0);
        d = $urandom;
        do_xfer(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 7) == 0), v, e);
      end
      check_outs();
    end
  endtask

  initial begin
    reset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    sobel_done = 0; dut_sel = 0;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      dut_sel = s;
      run_directed();
      run_random(150);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
